vedic4_seq_mult: RTL

- Sequential 4x4 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier. Four 2x2 partial products are formed combinationally from latched operands.
- The partial products are summed by a single shared sixbit_adder instance over three scheduled add cycles.
- This trades area for latency relative to the fully combinational 4x4 multiplier tree.
- The block owns the adder, its operand muxing, the FSM sequencing and the start/busy/done handshake.

---
 rtl/vedic4_seq_mult.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vedic4_seq_mult.sv
// Sequential 4x4 Vedic (Urdhva-Tiryagbhyam) multiplier sharing one 6-bit adder over three steps.
// Optional VEDIC4_BACK_TO_BACK_EN: accept a new start in DONE and go straight to ADD1.

module sixbit_adder (
    input  logic [5:0] x,
    input  logic [5:0] y,
    output logic [5:0] sum
);
    assign sum = x + y;
endmodule

module vedic4_seq_mult #(
    parameter int unsigned STALL_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] p
);

    typedef enum logic [2:0] {
        StIdle,
        StAdd1,
        StWait1,
        StAdd2,
        StWait2,
        StAdd3,
        StDone
    } state_t;

    // Last stall count value; unused when STALL_CYCLES is zero.
    localparam logic [2:0] CntLast = 3'((STALL_CYCLES == 0) ? 0 : STALL_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] a_q, b_q;
    logic [5:0] t_q;
    logic [3:0] u_hi_q;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] p_q;
    logic       done_q;
    logic       capture;

    logic [3:0] q0, q1, q2, q3;
    logic [5:0] add_x, add_y, add_sum;

    assign q0 = {2'b00, a_q[1:0]} * {2'b00, b_q[1:0]};
    assign q1 = {2'b00, a_q[3:2]} * {2'b00, b_q[1:0]};
    assign q2 = {2'b00, a_q[1:0]} * {2'b00, b_q[3:2]};
    assign q3 = {2'b00, a_q[3:2]} * {2'b00, b_q[3:2]};

    sixbit_adder u_adder (
        .x   (add_x),
        .y   (add_y),
        .sum (add_sum)
    );

    always_comb begin
        add_x = 6'd0;
        add_y = 6'd0;
        case (state_q)
            StAdd1: begin
                add_x = {2'b00, q1};
                add_y = {2'b00, q2};
            end
            StAdd2: begin
                add_x = t_q;
                add_y = {4'b0000, q0[3:2]};
            end
            StAdd3: begin
                add_x = {2'b00, u_hi_q};
                add_y = {2'b00, q3};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = StAdd1;
                end
            end
            StAdd1: begin
                if (STALL_CYCLES > 0) begin
                    state_d = StWait1;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = StAdd2;
                end
            end
            StWait1: begin
                if (cnt_q == CntLast) state_d = StAdd2;
                else                  cnt_d   = cnt_q + 3'd1;
            end
            StAdd2: begin
                if (STALL_CYCLES > 0) begin
                    state_d = StWait2;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = StAdd3;
                end
            end
            StWait2: begin
                if (cnt_q == CntLast) state_d = StAdd3;
                else                  cnt_d   = cnt_q + 3'd1;
            end
            StAdd3: state_d = StDone;
            StDone: begin
`ifdef VEDIC4_BACK_TO_BACK_EN
                if (start) begin
                    capture = 1'b1;
                    state_d = StAdd1;
                end else begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            t_q     <= 6'd0;
            u_hi_q  <= 4'd0;
            cnt_q   <= 3'd0;
            p_q     <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_d == StDone);
            if (capture) begin
                a_q <= a;
                b_q <= b;
            end
            if (state_q == StAdd1) t_q <= add_sum;
            // Low two bits of U go straight to the product; only the carry part is kept.
            if (state_q == StAdd2) begin
                u_hi_q   <= add_sum[5:2];
                p_q[1:0] <= q0[1:0];
                p_q[3:2] <= add_sum[1:0];
            end
            if (state_q == StAdd3) p_q[7:4] <= add_sum[3:0];
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign p    = p_q;

endmodule
